nibble_packer: RTL and testbench
================================

Name: nibble_packer

Overview:
- Parametrised narrow-to-wide data packer. Accepts RATIO input beats of IN_W bits and emits one OUT_W = IN_W*RATIO word.
- Successor to the fixed 4-to-8 packer. Adds:
  - configurable width, ratio and slot order;
  - valid/ready backpressure on both sides;
  - flushing of partial words.
- Sits between a narrow source (serial/nibble interface) and wide datapath consumers.

Parameters:
- IN_W, 4, input beat width in bits (>=1)
- RATIO, 2, input beats per output word (>=2)
- MSB_FIRST, 1, 1: first beat fills the most significant slot; 0: first beat fills the least significant slot

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- DATA_IN  in  IN_W  input beat
- DATA_VALID  in  1  input beat valid
- DATA_READY  out  1  packer can accept a beat this cycle
- FLUSH  in  1  single-cycle request to emit the current partial word
- DATA_OUT  out  IN_W*RATIO  packed output word
- OUTPUT_VALID  out  1  DATA_OUT holds a valid word
- OUTPUT_READY  in  1  downstream accepts DATA_OUT this cycle
- OUT_BEATS  out  $clog2(RATIO+1)  number of valid beats in DATA_OUT
- SLOT_EN  out  RATIO  one-hot: slot the next accepted beat will write (generalises EN_H/EN_L)

Behaviour:
- Reset (RESET=0), immediately and asynchronously:
  - Cleared to 0: accumulator ACC, beat counter CNT, DATA_OUT, OUTPUT_VALID, OUT_BEATS, flush-pending flag FP.
  - SLOT_EN = one-hot slot 0. DATA_READY forced 0 while RESET=0.
- Slot mapping, beat index k:
  - MSB_FIRST=1: DATA_OUT[OUT_W-1-k*IN_W -: IN_W].
  - MSB_FIRST=0: DATA_OUT[k*IN_W +: IN_W].
- Definitions:
  - accept = DATA_VALID & DATA_READY.
  - drain = OUTPUT_VALID & OUTPUT_READY.
  - free = !OUTPUT_VALID | OUTPUT_READY.
- DATA_READY = RESET & !FP & (CNT<RATIO-1 | free). Combinational from state and OUTPUT_READY; no path from DATA_VALID.
- Accept with CNT<RATIO-1: write slot CNT of ACC, CNT++.
- Accept with CNT==RATIO-1 (completing beat):
  - DATA_OUT <= ACC with last slot filled; OUT_BEATS <= RATIO; OUTPUT_VALID <= 1.
  - ACC <= 0; CNT <= 0.
- Latency: completing beat accepted at edge n -> OUTPUT_VALID=1 from edge n onward (visible in the following cycle).
- Output register:
  - Holds value while OUTPUT_VALID & !OUTPUT_READY.
  - drain with no load: OUTPUT_VALID <= 0. DATA_OUT keeps its last value.
  - drain and load in the same cycle: new word replaces old; OUTPUT_VALID stays 1, so there are no bubbles.
- FLUSH:
  - Beat accepted in the same cycle as FLUSH: the beat is applied first.
  - If that beat completes the word, FLUSH is a no-op.
  - Otherwise, effective count C = CNT (after the beat) > 0 and free: DATA_OUT <= ACC (unfilled slots zero); OUT_BEATS <= C; OUTPUT_VALID <= 1; ACC, CNT <= 0.
  - C > 0 and !free: FP <= 1. DATA_READY=0 until the partial word is loaded on the first free cycle, then FP <= 0.
  - C == 0: no-op. No empty words are ever emitted.
  - FLUSH while FP=1: ignored.
- SLOT_EN = 1 << CNT. Index is CNT regardless of MSB_FIRST; the slot bit position follows the mapping above.
- CNT wraps RATIO-1 -> 0 only on a completing beat or flush.
- Reset asserted mid-word or mid-flush:
  - Partial data and pending output are discarded.
  - After release, packing restarts at slot 0.
- Throughput: with OUTPUT_READY held 1, one word every RATIO accepted beats, with no stall cycles.

Test Plan:
- Defaults (IN_W=4, RATIO=2, MSB_FIRST=1): beats 0xF, 0x5 on consecutive cycles -> OUTPUT_VALID=1 the cycle after the second beat; DATA_OUT=0xF5; OUT_BEATS=2; SLOT_EN sequence 01,10,01.
- MSB_FIRST=0, same stimulus -> DATA_OUT=0x5F.
- Backpressure, OUTPUT_READY=0, beats 0xA,0xB,0xC,0xD:
  - 0xAB is held stable.
  - 0xC is accepted; DATA_READY=0 while 0xD is presented.
  - Raise OUTPUT_READY for one cycle -> 0xAB drained and 0xD accepted that cycle; next word 0xCD.
- Flush, RATIO=4: beats 0x1, 0x2 then FLUSH -> DATA_OUT=0x1200, OUT_BEATS=2, CNT=0.
  - FLUSH again with no data -> no OUTPUT_VALID.
  - FLUSH while the output is stalled -> DATA_READY=0 until the partial word loads.
- Reset mid-word: accept 0x9, pull RESET low asynchronously mid-cycle -> all outputs 0 immediately. After release, beats 0x3, 0x4 -> DATA_OUT=0x34.
- Streaming: 16 random beats back-to-back, OUTPUT_READY=1 -> 8 words, one every 2 cycles, matching the scoreboard; DATA_READY never drops.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer: packs RATIO narrow beats of IN_W bits into one IN_W*RATIO word.
// Valid/ready handshakes on both sides. FLUSH emits a partial word with the
// unfilled slots left at zero. A flush that meets a stalled output is held
// pending, and the input is blocked, until the output register frees up.
module nibble_packer #(
  parameter int IN_W      = 4,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [IN_W-1:0]             DATA_IN,
  input  logic                        DATA_VALID,
  output logic                        DATA_READY,
  input  logic                        FLUSH,
  output logic [IN_W*RATIO-1:0]       DATA_OUT,
  output logic                        OUTPUT_VALID,
  input  logic                        OUTPUT_READY,
  output logic [$clog2(RATIO+1)-1:0]  OUT_BEATS,
  output logic [RATIO-1:0]            SLOT_EN
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [OUT_W-1:0] acc, acc_nx, acc_beat, load_word;
  logic [CW-1:0]    cnt, cnt_nx, load_beats;
  logic             fp, fp_nx, load;
  logic             accept, drain, free, completing;

  assign free       = !OUTPUT_VALID | OUTPUT_READY;
  assign DATA_READY = RESET & !fp & ((cnt < LAST) | free);
  assign accept     = DATA_VALID & DATA_READY;
  assign drain      = OUTPUT_VALID & OUTPUT_READY;
  assign completing = accept & (cnt == LAST);

  // One-hot slot pointer for the next accepted beat; the index is the beat count.
  always_comb begin
    SLOT_EN = '0;
    for (int k = 0; k < RATIO; k++) begin
      SLOT_EN[k] = (cnt == CW'(k));
    end
  end

  // Accumulator with the incoming beat dropped into its slot.
  always_comb begin
    acc_beat = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CW'(k)) begin
        acc_beat[((MSB_FIRST != 0) ? (RATIO - 1 - k) : k) * IN_W +: IN_W] = DATA_IN;
      end
    end
  end

  // Next state: the beat is applied first, then a pending or new flush.
  always_comb begin
    acc_nx     = acc;
    cnt_nx     = cnt;
    fp_nx      = fp;
    load       = 1'b0;
    load_word  = '0;
    load_beats = '0;

    if (accept) begin
      if (completing) begin
        load       = 1'b1;
        load_word  = acc_beat;
        load_beats = CW'(RATIO);
        acc_nx     = '0;
        cnt_nx     = '0;
      end else begin
        acc_nx = acc_beat;
        cnt_nx = cnt + CW'(1);
      end
    end

    if (fp) begin
      // Input is blocked while pending, so acc/cnt still hold the partial word.
      if (free) begin
        load       = 1'b1;
        load_word  = acc;
        load_beats = cnt;
        acc_nx     = '0;
        cnt_nx     = '0;
        fp_nx      = 1'b0;
      end
    end else if (FLUSH && !completing && (cnt_nx != '0)) begin
      if (free) begin
        load       = 1'b1;
        load_word  = acc_nx;
        load_beats = cnt_nx;
        acc_nx     = '0;
        cnt_nx     = '0;
      end else begin
        fp_nx = 1'b1;
      end
    end
  end

  // Packing state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc <= '0;
      cnt <= '0;
      fp  <= 1'b0;
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      fp  <= fp_nx;
    end
  end

  // Output register: a load replaces the word even while draining (no bubble).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DATA_OUT     <= '0;
      OUT_BEATS    <= '0;
      OUTPUT_VALID <= 1'b0;
    end else if (load) begin
      DATA_OUT     <= load_word;
      OUT_BEATS    <= load_beats;
      OUTPUT_VALID <= 1'b1;
    end else if (drain) begin
      OUTPUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: three instances share the inputs (defaults,
// LSB-first, and RATIO=4); each section resets and then looks at the
// instance it exercises.
module tb_nibble_packer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET, dv, flush, ordy;
  logic [3:0] din;

  logic [7:0]  a_do, b_do;
  logic [15:0] c_do;
  logic        a_rdy, b_rdy, c_rdy, a_ov, b_ov, c_ov;
  logic [1:0]  a_beats, b_beats, a_slot, b_slot;
  logic [2:0]  c_beats;
  logic [3:0]  c_slot;

  int checks = 0;
  int errors = 0;

  nibble_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .DATA_IN(din), .DATA_VALID(dv), .DATA_READY(a_rdy),
    .FLUSH(flush), .DATA_OUT(a_do), .OUTPUT_VALID(a_ov), .OUTPUT_READY(ordy),
    .OUT_BEATS(a_beats), .SLOT_EN(a_slot));

  nibble_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .DATA_IN(din), .DATA_VALID(dv), .DATA_READY(b_rdy),
    .FLUSH(flush), .DATA_OUT(b_do), .OUTPUT_VALID(b_ov), .OUTPUT_READY(ordy),
    .OUT_BEATS(b_beats), .SLOT_EN(b_slot));

  nibble_packer #(.IN_W(4), .RATIO(4), .MSB_FIRST(1)) dut_c (
    .CLK(CLK), .RESET(RESET), .DATA_IN(din), .DATA_VALID(dv), .DATA_READY(c_rdy),
    .FLUSH(flush), .DATA_OUT(c_do), .OUTPUT_VALID(c_ov), .OUTPUT_READY(ordy),
    .OUT_BEATS(c_beats), .SLOT_EN(c_slot));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
  endtask

  // Reference packing: beat k lands in slot k, counted from the MSB or the LSB.
  function automatic logic [15:0] pack(input logic [3:0] b0, input logic [3:0] b1,
                                       input logic [3:0] b2, input logic [3:0] b3,
                                       input int n, input int ratio, input bit msb);
    logic [15:0] w;
    logic [3:0]  b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    w = '0;
    for (int k = 0; k < n; k++) begin
      w = w | (16'(b[k]) << ((msb ? (ratio - 1 - k) : k) * 4));
    end
    return w;
  endfunction

  logic [3:0] beats [$];
  logic [7:0] exp_q [$];
  logic [7:0] exp_w;
  bit         acc_s, drn_s;

  initial begin
    RESET = 1'b0; din = '0; dv = 1'b0; flush = 1'b0; ordy = 1'b1;

    // Reset state
    #3;
    chk("rst_do", a_do, 0);
    chk("rst_ov", a_ov, 0);
    chk("rst_beats", a_beats, 0);
    chk("rst_slot", a_slot, 2'b01);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_c_slot", c_slot, 4'b0001);
    tick();
    RESET = 1'b1;
    #1;
    chk("rel_rdy", a_rdy, 1);

    // Basic packing, both slot orders
    din = 4'hF; dv = 1'b1;
    tick();
    chk("b1_slot", a_slot, 2'b10);
    chk("b1_ov", a_ov, 0);
    din = 4'h5;
    tick();
    chk("b2_ov", a_ov, 1);
    chk("b2_do_msb", a_do, pack(4'hF, 4'h5, 0, 0, 2, 2, 1));
    chk("b2_do_lsb", b_do, pack(4'hF, 4'h5, 0, 0, 2, 2, 0));
    chk("b2_beats", a_beats, 2);
    chk("b2_slot", a_slot, 2'b01);
    dv = 1'b0;
    tick();
    chk("drain_ov", a_ov, 0);
    chk("drain_keep", a_do, 8'hF5);

    // Backpressure
    do_reset();
    ordy = 1'b0;
    din = 4'hA; dv = 1'b1;
    tick();
    din = 4'hB;
    tick();
    chk("bp_ov", a_ov, 1);
    chk("bp_do", a_do, 8'hAB);
    din = 4'hC;
    #1 chk("bp_rdy_c", a_rdy, 1);
    tick();
    chk("bp_hold1", a_do, 8'hAB);
    din = 4'hD;
    #1 chk("bp_rdy_d", a_rdy, 0);
    tick();
    chk("bp_hold2", a_do, 8'hAB);
    chk("bp_hold_ov", a_ov, 1);
    chk("bp_rdy_d2", a_rdy, 0);
    ordy = 1'b1;
    #1 chk("bp_rdy_free", a_rdy, 1);
    tick();
    chk("bp_cd", a_do, 8'hCD);
    chk("bp_cd_ov", a_ov, 1);
    dv = 1'b0;
    tick();
    chk("bp_end_ov", a_ov, 0);

    // Flush on RATIO=4
    do_reset();
    ordy = 1'b1;
    din = 4'h1; dv = 1'b1;
    tick();
    din = 4'h2;
    tick();
    dv = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ov", c_ov, 1);
    chk("fl_do", c_do, pack(4'h1, 4'h2, 0, 0, 2, 4, 1));
    chk("fl_beats", c_beats, 2);
    chk("fl_slot", c_slot, 4'b0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_empty_ov", c_ov, 0);
    dv = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      din = 4'(i);
      tick();
    end
    chk("fl_full", c_do, 16'h1234);
    ordy = 1'b0;
    din = 4'h5;
    tick();
    dv = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk("fp_rdy1", c_rdy, 0);
    chk("fp_hold", c_do, 16'h1234);
    tick();
    chk("fp_rdy2", c_rdy, 0);
    ordy = 1'b1;
    #1 chk("fp_rdy3", c_rdy, 0);
    tick();
    chk("fp_do", c_do, pack(4'h5, 0, 0, 0, 1, 4, 1));
    chk("fp_beats", c_beats, 1);
    chk("fp_ov", c_ov, 1);
    #1 chk("fp_rdy4", c_rdy, 1);
    dv = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      din = 4'(i);
      tick();
    end
    din = 4'h9; flush = 1'b1;
    tick();
    dv = 1'b0; flush = 1'b0;
    chk("flc_do", c_do, 16'h6789);
    chk("flc_beats", c_beats, 4);
    tick();
    chk("flc_noextra", c_ov, 0);

    // Reset mid-word
    do_reset();
    ordy = 1'b0;
    din = 4'h7; dv = 1'b1;
    tick();
    din = 4'h8;
    tick();
    chk("mr_78", a_do, 8'h78);
    din = 4'h9;
    tick();
    dv = 1'b0;
    #3 RESET = 1'b0;
    #1;
    chk("mr_do", a_do, 0);
    chk("mr_ov", a_ov, 0);
    chk("mr_beats", a_beats, 0);
    chk("mr_slot", a_slot, 2'b01);
    chk("mr_rdy", a_rdy, 0);
    tick();
    RESET = 1'b1; ordy = 1'b1;
    din = 4'h3; dv = 1'b1;
    tick();
    din = 4'h4;
    tick();
    chk("mr_34", a_do, 8'h34);
    chk("mr_34_beats", a_beats, 2);
    dv = 1'b0;
    tick();

    // Streaming, OUTPUT_READY held high
    beats.delete();
    for (int i = 0; i < 16; i++) begin
      din = 4'($urandom); dv = 1'b1;
      #1 chk("st_rdy", a_rdy, 1);
      beats.push_back(din);
      tick();
      if (beats.size() == 2) begin
        chk("st_ov", a_ov, 1);
        chk("st_do", a_do, pack(beats[0], beats[1], 0, 0, 2, 2, 1));
        beats.delete();
      end else begin
        chk("st_gap", a_ov, 0);
      end
    end
    dv = 1'b0;
    tick();

    // Random valid/ready against an ordered scoreboard
    beats.delete();
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      din = 4'($urandom); dv = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 1));
      #1;
      chk("rn_ov", a_ov, 32'(exp_q.size() != 0));
      acc_s = dv & a_rdy;
      drn_s = a_ov & ordy;
      if (drn_s) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk("rn_do", a_do, exp_w);
      end
      if (acc_s) begin
        beats.push_back(din);
        if (beats.size() == 2) begin
          exp_q.push_back(8'(pack(beats[0], beats[1], 0, 0, 2, 2, 1)));
          beats.delete();
        end
      end
      tick();
    end
    dv = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      #1;
      if (a_ov) begin
        exp_w = exp_q.pop_front();
        chk("rn_tail", a_do, exp_w);
      end
      tick();
    end
    chk("rn_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
